// File: rtl/pmic_pkg.sv
// Shared encodings between the power-sequencing FSM and the timer bank.
// Holds one-hot channel selects, channel indices and default delays.
package pmic_pkg;

  localparam int N_CH = 5;

  localparam logic [N_CH-1:0] CH_NULL = 5'b00000;
  localparam logic [N_CH-1:0] CH_T1   = 5'b00001;
  localparam logic [N_CH-1:0] CH_T2   = 5'b00010;
  localparam logic [N_CH-1:0] CH_T3   = 5'b00100;
  localparam logic [N_CH-1:0] CH_T4   = 5'b01000;
  localparam logic [N_CH-1:0] CH_T5   = 5'b10000;

  localparam int IDX_T1 = 0;
  localparam int IDX_T2 = 1;
  localparam int IDX_T3 = 2;
  localparam int IDX_T4 = 3;
  localparam int IDX_T5 = 4;

  localparam int DEF_DLY_T1 = 4;
  localparam int DEF_DLY_T2 = 6;
  localparam int DEF_DLY_T3 = 3;
  localparam int DEF_DLY_T4 = 5;
  localparam int DEF_DLY_T5 = 8;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_e;

  // A load strobe must name exactly one channel; zero or several is a protocol error.
  function automatic logic sel_err(input logic [N_CH-1:0] s);
    return (s == CH_NULL) || ((s & (s - 5'd1)) != CH_NULL);
  endfunction

endpackage

// File: rtl/pmic_timer_chan.sv
// One prescaled down-counting delay channel; done_pulse one clk wide, DLY*PRESCALE
// clks after the load edge. No backpressure: a load always restarts from full delay.
module pmic_timer_chan
  import pmic_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int PRE_W    = 8,
  parameter int DLY      = 4,
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic done_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] DLY_C   = CNT_W'(DLY);
  localparam logic [PRE_W-1:0] PRE_RLD = PRE_W'(PRESCALE - 1);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
    end
  end

  // Load has priority over expiry, so a reload on the expiry edge suppresses the pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = CH_RUN;
      cnt_d   = DLY_C;
      pre_d   = PRE_RLD;
    end else if (state_q == CH_RUN) begin
      if (pre_q != '0) begin
        pre_d = pre_q - PRE_W'(1);
      end else begin
        pre_d = PRE_RLD;
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = CH_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign done_pulse = done_q;
  assign busy       = (state_q == CH_RUN);

endmodule

// File: rtl/pmic_timer_bank.sv
// Five independent sequencing delay timers with sel decode and sticky protocol error.
// T[i] pulses one clk, DLY_i*PRESCALE clks after its load edge; loads are never refused.
module pmic_timer_bank
  import pmic_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int PRE_W    = 8,
  parameter int PRESCALE = 1,
  parameter int DLY_T1   = DEF_DLY_T1,
  parameter int DLY_T2   = DEF_DLY_T2,
  parameter int DLY_T3   = DEF_DLY_T3,
  parameter int DLY_T4   = DEF_DLY_T4,
  parameter int DLY_T5   = DEF_DLY_T5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] sel,
  input  logic            ld,
  output logic [N_CH-1:0] T,
  output logic [N_CH-1:0] busy,
  output logic            err
);

  localparam int DLY_ARR [N_CH] = '{DLY_T1, DLY_T2, DLY_T3, DLY_T4, DLY_T5};

  logic [N_CH-1:0] load_vec;
  logic            err_q, err_d;

  // Every selected channel loads even when the strobe is malformed.
  assign load_vec = ld ? sel : CH_NULL;

  always_comb begin
    err_d = err_q;
    if (ld && sel_err(sel)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    pmic_timer_chan #(
      .CNT_W   (CNT_W),
      .PRE_W   (PRE_W),
      .DLY     (DLY_ARR[i]),
      .PRESCALE(PRESCALE)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load_vec[i]),
      .done_pulse(T[i]),
      .busy      (busy[i])
    );
  end

endmodule

// File: tb/tb_pmic_timer_bank.sv
// Directed bench for pmic_timer_bank: default instance plus a PRESCALE=4 instance.
module tb_pmic_timer_bank;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] sel, sel2;
  logic       ld, ld2;
  logic [4:0] t_o, busy_o, t2_o, busy2_o;
  logic       err_o, err2_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pmic_timer_bank dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sel    (sel),
    .ld     (ld),
    .T      (t_o),
    .busy   (busy_o),
    .err    (err_o)
  );

  pmic_timer_bank #(.PRESCALE(4)) dut4 (
    .clk    (clk),
    .reset_n(reset_n),
    .sel    (sel2),
    .ld     (ld2),
    .T      (t2_o),
    .busy   (busy2_o),
    .err    (err2_o)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] s);
    ld  = 1'b1;
    sel = s;
    tick();
    ld  = 1'b0;
    sel = 5'b11111;
  endtask

  initial begin
    reset_n = 1'b0;
    ld = 1'b0; sel = 5'b00000;
    ld2 = 1'b0; sel2 = 5'b00000;
    #2;
    chk("rst_T", {3'b0, t_o}, 8'h00);
    chk("rst_busy", {3'b0, busy_o}, 8'h00);
    chk("rst_err", {7'b0, err_o}, 8'h00);
    tick(); tick();
    reset_n = 1'b1;

    // Idle channels never pulse; sel without ld ignored.
    sel = 5'b11111;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("idle_T", {3'b0, t_o}, 8'h00);
    end
    chk("idle_busy", {3'b0, busy_o}, 8'h00);
    chk("idle_err", {7'b0, err_o}, 8'h00);

    // Channel 0, DLY=4, PRESCALE=1.
    load(5'b00001);
    chk("c0_busy_E0", {3'b0, busy_o}, 8'h01);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("c0_T_early", {3'b0, t_o}, 8'h00);
      chk("c0_busy_run", {3'b0, busy_o}, 8'h01);
    end
    tick();
    chk("c0_T_pulse", {3'b0, t_o}, 8'h01);
    chk("c0_busy_done", {3'b0, busy_o}, 8'h00);
    tick();
    chk("c0_T_cleared", {3'b0, t_o}, 8'h00);

    // Channel 2 on the PRESCALE=4 instance: expiry 12 edges after load.
    ld2 = 1'b1; sel2 = 5'b00100;
    tick();
    ld2 = 1'b0; sel2 = 5'b00000;
    chk("p4_busy_E0", {3'b0, busy2_o}, 8'h04);
    for (int k = 1; k < 12; k++) begin
      tick();
      chk("p4_T_early", {3'b0, t2_o}, 8'h00);
    end
    chk("p4_busy_E11", {3'b0, busy2_o}, 8'h04);
    tick();
    chk("p4_T_pulse", {3'b0, t2_o}, 8'h04);
    chk("p4_busy_done", {3'b0, busy2_o}, 8'h00);
    tick();
    chk("p4_T_cleared", {3'b0, t2_o}, 8'h00);

    // Channel 1 reloaded at edge 5: pulse moves from edge 6 to edge 11.
    load(5'b00010);
    for (int k = 1; k < 5; k++) tick();
    load(5'b00010);
    for (int k = 6; k < 11; k++) begin
      tick();
      chk("c1_reload_T_early", {3'b0, t_o}, 8'h00);
    end
    tick();
    chk("c1_reload_T_pulse", {3'b0, t_o}, 8'h02);
    chk("c1_reload_busy", {3'b0, busy_o}, 8'h00);

    // Reload on the expiry edge itself: load wins, expiry at edge 12.
    load(5'b00010);
    for (int k = 1; k < 6; k++) tick();
    load(5'b00010);
    chk("c1_exp_reload_T", {3'b0, t_o}, 8'h00);
    chk("c1_exp_reload_busy", {3'b0, busy_o}, 8'h02);
    for (int k = 7; k < 12; k++) begin
      tick();
      chk("c1_exp_reload_T_early", {3'b0, t_o}, 8'h00);
    end
    tick();
    chk("c1_exp_reload_T_pulse", {3'b0, t_o}, 8'h02);

    // Channel 0 at edge 0, channel 4 at edge 4 (same edge as ch0 expiry).
    load(5'b00001);
    for (int k = 1; k < 4; k++) tick();
    load(5'b10000);
    chk("c04_T_ch0", {3'b0, t_o}, 8'h01);
    chk("c04_busy_ch4", {3'b0, busy_o}, 8'h10);
    for (int k = 5; k < 12; k++) begin
      tick();
      chk("c04_T_quiet", {3'b0, t_o}, 8'h00);
    end
    tick();
    chk("c04_T_ch4", {3'b0, t_o}, 8'h10);
    chk("c04_busy_end", {3'b0, busy_o}, 8'h00);
    chk("c04_err", {7'b0, err_o}, 8'h00);

    // Protocol errors.
    load(5'b00000);
    chk("null_err", {7'b0, err_o}, 8'h01);
    chk("null_busy", {3'b0, busy_o}, 8'h00);
    load(5'b00011);
    chk("multi_err", {7'b0, err_o}, 8'h01);
    chk("multi_busy", {3'b0, busy_o}, 8'h03);
    for (int k = 0; k < 8; k++) tick();
    chk("err_sticky", {7'b0, err_o}, 8'h01);
    chk("multi_idle", {3'b0, busy_o}, 8'h00);

    // Asynchronous reset mid-count on channel 4.
    load(5'b10000);
    tick(); tick(); tick();
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_T", {3'b0, t_o}, 8'h00);
    chk("arst_busy", {3'b0, busy_o}, 8'h00);
    chk("arst_err", {7'b0, err_o}, 8'h00);
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("arst_no_pulse", {3'b0, t_o}, 8'h00);
    end
    chk("arst_busy_after", {3'b0, busy_o}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
